// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch stage: issues imem requests, presents fetched
// instructions to decode, handles stall and jump/branch redirects. Optional macro: MISALIGN_TRAP_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] pc_branch,
  input  logic        jump_en,
  input  logic [31:0] pc_jump,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        misalign_err
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_RESET, S_FETCH, S_HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_target;
  logic        redirect_pending;

  logic        redirect_c;
  logic [31:0] raw_target_c;
  logic [31:0] target_c;
  logic        bad_target_c;

  // Redirect decode: jump wins over branch; low target bits never reach the PC.
  always_comb begin
    redirect_c   = jump_en | branch_taken;
    raw_target_c = jump_en ? pc_jump : pc_branch;
    target_c     = {raw_target_c[31:2], 2'b00};
    bad_target_c = TRAP_EN && redirect_c && (raw_target_c[1:0] != 2'b00);
  end

  assign imem_addr   = pc;
  assign if_pc_plus4 = if_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_RESET;
      pc               <= RESET_PC;
      pend_target      <= RESET_PC;
      redirect_pending <= 1'b0;
      imem_req         <= 1'b0;
      if_valid         <= 1'b0;
      if_instr         <= NOP_INSTR;
      if_pc            <= RESET_PC;
      misalign_err     <= 1'b0;
    end else if (!misalign_err) begin
      if (bad_target_c) begin
        // Misaligned redirect: park with no request until reset.
        misalign_err     <= 1'b1;
        state            <= S_HOLD;
        imem_req         <= 1'b0;
        if_valid         <= 1'b0;
        redirect_pending <= 1'b0;
      end else begin
        case (state)
          S_RESET: begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            if (redirect_c) pc <= target_c;
          end
          S_FETCH: begin
            if (imem_ack) begin
              if (redirect_c) begin
                pc               <= target_c;
                redirect_pending <= 1'b0;
              end else if (redirect_pending) begin
                pc               <= pend_target;
                redirect_pending <= 1'b0;
              end else begin
                if_instr <= imem_rdata;
                if_pc    <= pc;
                if_valid <= 1'b1;
                pc       <= pc + 32'd4;
                state    <= S_HOLD;
                imem_req <= 1'b0;
              end
            end else if (redirect_c) begin
              // Address must stay stable until ack; remember where to go.
              redirect_pending <= 1'b1;
              pend_target      <= target_c;
            end
          end
          S_HOLD: begin
            if (redirect_c) begin
              if_valid <= 1'b0;
              if_instr <= NOP_INSTR;
              pc       <= target_c;
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end else if (!stall) begin
              if_valid <= 1'b0;
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end
          end
          default: begin
            state    <= S_RESET;
            imem_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
PC register and instruction-fetch stage; consumes the branch target produced by the branch adder, plus a jump target from execute.
- Drives the instruction-memory request handshake.
- Presents a valid instruction, with its PC, to decode.
- The presented PC feeds the branch adder's PC input.
- Supports stall from decode and flush/redirect from execute.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
NOP_INSTR, 32'h0000_0013, value of if_instr after reset/flush.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
stall  input  1  decode cannot accept; hold presented instruction
branch_taken  input  1  redirect to pc_branch (qualified by execute)
pc_branch  input  32  branch target from branch adder
jump_en  input  1  redirect to pc_jump; priority over branch_taken
pc_jump  input  32  jump target (JAL/JALR)
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address
imem_ack  input  1  memory response valid; may assert in the same cycle as imem_req
imem_rdata  input  32  instruction word, valid with imem_ack
if_valid  output  1  if_instr/if_pc hold a valid instruction
if_instr  output  32  fetched instruction
if_pc  output  32  PC of if_instr
if_pc_plus4  output  32  if_pc + 4, combinational
misalign_err  output  1  sticky misaligned-target flag (MISALIGN_TRAP_EN only, else tied 0)

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n); sampled only on the rising edge.
- Reset values:
  - state=S_RESET, pc=RESET_PC, imem_req=0, if_valid=0.
  - if_instr=NOP_INSTR, if_pc=RESET_PC.
  - redirect_pending=0, misalign_err=0.
- Redirect:
  - Redirect = jump_en | branch_taken; target = jump_en ? pc_jump : pc_branch.
  - Redirect overrides stall.
- FSM states S_RESET, S_FETCH, S_HOLD:
  - S_RESET: imem_req=0. Next cycle goes to S_FETCH, or redirects (pc<=target, S_FETCH). Any imem_ack in this state is ignored.
  - S_FETCH: imem_req=1, imem_addr=pc. imem_addr is stable while imem_req=1 and no ack.
  - S_FETCH, ack with no redirect and redirect_pending=0: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, go to S_HOLD.
  - S_FETCH, ack with redirect this cycle: discard data, pc<=target, redirect_pending<=0, stay in S_FETCH. The new request issues next cycle.
  - S_FETCH, ack with redirect_pending=1: discard data, pc<=pend_target, redirect_pending<=0, stay in S_FETCH.
  - S_FETCH, redirect without ack: redirect_pending<=1, pend_target<=target. Address is unchanged, and a later redirect overwrites pend_target.
  - S_HOLD: imem_req=0; if_instr/if_pc/if_valid stable while stall=1.
  - S_HOLD, stall=0: if_valid<=0, go to S_FETCH. The instruction is consumed in this cycle.
  - S_HOLD, redirect: if_valid<=0, if_instr<=NOP_INSTR, pc<=target, go to S_FETCH.
- Throughput: max one instruction per 2 cycles with zero-wait memory.
- Arithmetic:
  - pc+4 and if_pc_plus4 are modulo 2^32; 0xFFFF_FFFC wraps to 0.
  - Without the optional feature, target bits [1:0] are forced to 0 on load.
- Reset mid-request: the outstanding request is abandoned and its late ack is ignored in S_RESET.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a redirect target with bits[1:0]!=0 sets misalign_err (sticky until reset). pc is not updated, and the FSM parks in S_HOLD with if_valid=0 and imem_req=0 until reset.
- Undefined: misalign_err is tied to 0 and target[1:0] are cleared.

Test Plan:
- Reset and first fetch: rst_n=0 for 2 cycles, RESET_PC=0 -> imem_req=0 during reset, then imem_req=1 with imem_addr=0x0 on the 2nd cycle after release.
- Zero-wait fetch: ack in the same cycle with rdata=0x00500093 -> next cycle if_valid=1, if_instr=0x00500093, if_pc=0x0, if_pc_plus4=0x4; next request addr=0x4.
- Branch while waiting: request to 0x8 outstanding, branch_taken=1 with pc_branch=0x40, ack 2 cycles later -> imem_addr stays 0x8 until ack, data discarded, if_valid stays 0, next request addr=0x40.
- Stall hold, then redirect priority: stall=1 for 3 cycles in S_HOLD -> if_instr/if_pc stable, imem_req=0. Then jump_en=1 (0x100) and branch_taken=1 (0x200) together with stall=1 -> if_valid=0, next request addr=0x100.
- Wrap-around: RESET_PC=0xFFFF_FFFC, two acked fetches -> second request addr=0x0000_0000.
- MISALIGN_TRAP_EN defined: branch to 0x42 -> misalign_err=1, imem_req=0 thereafter. Undefined: next request addr=0x40.
